// File: rtl/sdio_blkcheck.sv
// Block framing checker: counts words per block, flags short/long blocks, counts completed blocks.
// Latency: error pulses and count update one cycle after the word-accept strobe.
// Backpressure: none; observes the accept strobe only, so stalls never stretch or delay pulses.
module sdio_blkcheck #(
    parameter int BLKWORDS = 128
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stb,
    input  logic        i_last,
    output logic        o_at_end,
    output logic        o_err_short,
    output logic        o_err_long,
    output logic [15:0] o_blk_count
);
    localparam int CW = $clog2(BLKWORDS) + 1;
    localparam logic [CW-1:0] LASTW = CW'(BLKWORDS - 1);

    logic [CW-1:0] wcnt;

    // High while the next accepted word is the final one of a full-size block.
    assign o_at_end = (wcnt == LASTW);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wcnt        <= '0;
            o_err_short <= 1'b0;
            o_err_long  <= 1'b0;
            o_blk_count <= '0;
        end else begin
            o_err_short <= i_stb && i_last && !o_at_end;
            o_err_long  <= i_stb && !i_last && o_at_end;
            if (i_stb) begin
                // A missing s_last still closes the block so the count resynchronises.
                if (i_last || o_at_end) begin
                    wcnt        <= '0;
                    o_blk_count <= o_blk_count + 16'd1;
                end else begin
                    wcnt <= wcnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/sdio_ostream_bytes.sv
// Serialises SW-bit stream words into bytes, one byte per cycle, with block framing checks.
// Latency: first byte of a word is valid the cycle after the word handshake.
// Backpressure: holds m_data/m_last while m_ready=0; s_ready only rises as the last byte leaves.
module sdio_ostream_bytes #(
    parameter int SW                = 32,
    parameter bit OPT_LITTLE_ENDIAN = 1'b0,
    parameter int BLKWORDS          = 128
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [SW-1:0] s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [7:0]    m_data,
    output logic          m_last,
    output logic          o_err_short,
    output logic          o_err_long,
    output logic [15:0]   o_blk_count
);
    localparam int NB = SW / 8;
    localparam int IW = $clog2(NB);
    localparam logic [IW-1:0] LASTB = IW'(NB - 1);

    typedef enum logic {EMPTY, SHIFT} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] hold;
    logic [IW-1:0] byte_idx;
    logic          hold_last;
    logic          at_last_byte;
    logic          word_acc;
    logic          byte_acc;
    logic          blk_at_end;

    assign m_valid      = (state == SHIFT);
    assign at_last_byte = (byte_idx == LASTB);
    assign s_ready      = !m_valid || (m_ready && at_last_byte);
    assign word_acc     = s_valid && s_ready;
    assign byte_acc     = m_valid && m_ready;
    assign m_data       = OPT_LITTLE_ENDIAN ? hold[7:0] : hold[SW-1:SW-8];
    assign m_last       = hold_last && at_last_byte;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (word_acc) state_nxt = SHIFT;
            SHIFT:   if (byte_acc && at_last_byte && !word_acc) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // A word accept while SHIFT implies its last byte is leaving, so reload wins over shift.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            hold      <= '0;
            byte_idx  <= '0;
            hold_last <= 1'b0;
        end else if (word_acc) begin
            hold      <= s_data;
            hold_last <= s_last || blk_at_end;
            byte_idx  <= '0;
        end else if (byte_acc && !at_last_byte) begin
            byte_idx <= byte_idx + IW'(1);
            hold     <= OPT_LITTLE_ENDIAN ? {8'h00, hold[SW-1:8]} : {hold[SW-9:0], 8'h00};
        end
    end

    sdio_blkcheck #(
        .BLKWORDS(BLKWORDS)
    ) u_blkcheck (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_stb       (word_acc),
        .i_last      (s_last),
        .o_at_end    (blk_at_end),
        .o_err_short (o_err_short),
        .o_err_long  (o_err_long),
        .o_blk_count (o_blk_count)
    );
endmodule

// File: tb/tb_sdio_ostream_bytes.sv
// Bench for sdio_ostream_bytes: big- and little-endian instances share one stimulus stream.
module tb_sdio_ostream_bytes;
    logic        i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic        i_reset_n, s_valid, s_last, m_ready;
    logic [31:0] s_data;
    logic        s_ready, m_valid, m_last, o_err_short, o_err_long;
    logic [7:0]  m_data;
    logic [15:0] o_blk_count;
    logic        le_s_ready, le_m_valid, le_m_last, le_err_short, le_err_long;
    logic [7:0]  le_m_data;
    logic [15:0] le_blk_count;

    sdio_ostream_bytes #(.SW(32), .OPT_LITTLE_ENDIAN(1'b0), .BLKWORDS(128)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .o_err_short(o_err_short), .o_err_long(o_err_long), .o_blk_count(o_blk_count));

    sdio_ostream_bytes #(.SW(32), .OPT_LITTLE_ENDIAN(1'b1), .BLKWORDS(128)) dut_le (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .s_valid(s_valid), .s_ready(le_s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(le_m_valid), .m_ready(m_ready), .m_data(le_m_data), .m_last(le_m_last),
        .o_err_short(le_err_short), .o_err_long(le_err_long), .o_blk_count(le_blk_count));

    typedef struct {
        logic [31:0] word;
        logic [3:0]  rdy;      // m_ready pattern, MSB applied first, repeating every 4 cycles
        logic [31:0] exp_be;   // expected bytes, first emitted in [31:24]
        logic [31:0] exp_le;
    } vec_t;

    vec_t        vecs[4];
    int          total = 0;
    int          bad = 0;
    logic [31:0] stim_w[$];
    logic        stim_l[$];
    logic [7:0]  got_be[$];
    logic [7:0]  got_le[$];
    int          last_idx[$];
    int          n_short, n_long, le_short, le_long;
    int          stab_bad, srdy_bad, sync_bad;
    int          first_acc, first_vld, first_byte, last_byte;
    bit          run_done;
    logic [15:0] exp_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Block of n words whose bytes count up 0,1,2,... mod 256; s_last on word last_at (-1: none).
    task automatic load_block(input int n, input int last_at);
        stim_w.delete();
        stim_l.delete();
        for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            b = 8'((4 * k) & 255);
            stim_w.push_back({b, b + 8'd1, b + 8'd2, b + 8'd3});
            stim_l.push_back(k == last_at);
        end
    endtask

    task automatic run_stream(input logic [3:0] rdy, input int limit);
        int         widx, bcnt;
        bit         hold_prev;
        logic [7:0] prev_d;
        widx = 0; bcnt = 0; hold_prev = 0; prev_d = '0;
        got_be.delete(); got_le.delete(); last_idx.delete();
        n_short = 0; n_long = 0; le_short = 0; le_long = 0;
        stab_bad = 0; srdy_bad = 0; sync_bad = 0;
        first_acc = -1; first_vld = -1; first_byte = -1; last_byte = -1;
        run_done = 0;
        for (int c = 0; c < limit && !run_done; c++) begin
            @(negedge i_clk);
            if (widx == stim_w.size() && !m_valid) begin
                run_done = 1;
                s_valid  = 1'b0;
                m_ready  = 1'b0;
            end else begin
                m_ready = rdy[3 - (c % 4)];
                s_valid = (widx < stim_w.size());
                if (s_valid) begin
                    s_data = stim_w[widx];
                    s_last = stim_l[widx];
                end
                #1;
                if (o_err_short)  n_short++;
                if (o_err_long)   n_long++;
                if (le_err_short) le_short++;
                if (le_err_long)  le_long++;
                if (hold_prev && (!m_valid || m_data !== prev_d)) stab_bad++;
                if (s_ready !== (!m_valid || (m_ready && bcnt == 3))) srdy_bad++;
                if (le_m_valid !== m_valid || le_s_ready !== s_ready || le_m_last !== m_last) sync_bad++;
                if (m_valid && first_vld < 0) first_vld = c;
                if (m_valid && m_ready) begin
                    got_be.push_back(m_data);
                    got_le.push_back(le_m_data);
                    if (m_last) last_idx.push_back(got_be.size() - 1);
                    if (first_byte < 0) first_byte = c;
                    last_byte = c;
                    bcnt = (bcnt == 3) ? 0 : bcnt + 1;
                end
                if (s_valid && s_ready) begin
                    if (first_acc < 0) first_acc = c;
                    widx++;
                end
                hold_prev = m_valid && !m_ready;
                prev_d    = m_data;
            end
        end
        chk("run_complete", 64'(run_done), 64'd1);
    endtask

    task automatic common_checks(input string nm);
        chk({nm, "_stable"}, 64'(stab_bad), 64'd0);
        chk({nm, "_s_ready"}, 64'(srdy_bad), 64'd0);
        chk({nm, "_le_sync"}, 64'(sync_bad), 64'd0);
        chk({nm, "_latency"}, 64'(first_vld), 64'(first_acc + 1));
        chk({nm, "_blk_count"}, 64'(o_blk_count), 64'(exp_cnt));
        chk({nm, "_le_blk_count"}, 64'(le_blk_count), 64'(exp_cnt));
        chk({nm, "_le_errs"}, 64'({le_short, le_long}), 64'({n_short, n_long}));
    endtask

    // Counting-pattern byte check: BE byte n is n mod 256; LE reverses within each word.
    task automatic pattern_check(input string nm);
        int be_bad, le_bad;
        be_bad = 0; le_bad = 0;
        for (int n = 0; n < got_be.size(); n++) begin
            if (got_be[n] !== 8'(n & 255)) be_bad++;
            if (got_le[n] !== 8'((n ^ 3) & 255)) le_bad++;
        end
        chk({nm, "_be_bytes_bad"}, 64'(be_bad), 64'd0);
        chk({nm, "_le_bytes_bad"}, 64'(le_bad), 64'd0);
    endtask

    initial begin
        vecs[0] = '{word: 32'h11223344, rdy: 4'b1111, exp_be: 32'h11223344, exp_le: 32'h44332211};
        vecs[1] = '{word: 32'hA5B6C7D8, rdy: 4'b1001, exp_be: 32'hA5B6C7D8, exp_le: 32'hD8C7B6A5};
        vecs[2] = '{word: 32'h00FF00FF, rdy: 4'b1010, exp_be: 32'h00FF00FF, exp_le: 32'hFF00FF00};
        vecs[3] = '{word: 32'hDEADBEEF, rdy: 4'b1100, exp_be: 32'hDEADBEEF, exp_le: 32'hEFBEADDE};

        i_reset_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        exp_cnt = '0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_errs", 64'({o_err_short, o_err_long}), 64'd0);
        chk("rst_blk_count", 64'(o_blk_count), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Single-word blocks: each is a short block under varying backpressure.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] pbe, ple;
            string nm;
            nm = $sformatf("vec%0d", i);
            stim_w.delete(); stim_l.delete();
            stim_w.push_back(vecs[i].word);
            stim_l.push_back(1'b1);
            run_stream(vecs[i].rdy, 100);
            exp_cnt++;
            pbe = '0; ple = '0;
            for (int n = 0; n < 4 && n < got_be.size(); n++) begin
                pbe[31 - 8*n -: 8] = got_be[n];
                ple[31 - 8*n -: 8] = got_le[n];
            end
            chk({nm, "_nbytes"}, 64'(got_be.size()), 64'd4);
            chk({nm, "_be"}, 64'(pbe), 64'(vecs[i].exp_be));
            chk({nm, "_le"}, 64'(ple), 64'(vecs[i].exp_le));
            chk({nm, "_nlast"}, 64'(last_idx.size()), 64'd1);
            if (last_idx.size() > 0) chk({nm, "_last_pos"}, 64'(last_idx[0]), 64'd3);
            chk({nm, "_short"}, 64'(n_short), 64'd1);
            chk({nm, "_long"}, 64'(n_long), 64'd0);
            common_checks(nm);
        end

        // Full block at full throughput.
        load_block(128, 127);
        run_stream(4'b1111, 1000);
        exp_cnt++;
        chk("full_nbytes", 64'(got_be.size()), 64'd512);
        pattern_check("full");
        chk("full_nlast", 64'(last_idx.size()), 64'd1);
        if (last_idx.size() > 0) chk("full_last_pos", 64'(last_idx[0]), 64'd511);
        chk("full_errs", 64'({n_short, n_long}), 64'd0);
        chk("full_contiguous", 64'(last_byte - first_byte), 64'd511);
        chk("full_first_byte", 64'(first_byte), 64'(first_acc + 1));
        common_checks("full");

        // Short block of 11 words.
        load_block(11, 10);
        run_stream(4'b1111, 200);
        exp_cnt++;
        chk("short_nbytes", 64'(got_be.size()), 64'd44);
        pattern_check("short");
        chk("short_nlast", 64'(last_idx.size()), 64'd1);
        if (last_idx.size() > 0) chk("short_last_pos", 64'(last_idx[0]), 64'd43);
        chk("short_short", 64'(n_short), 64'd1);
        chk("short_long", 64'(n_long), 64'd0);
        common_checks("short");

        // 130 words, s_last on 129: forced end at word 127, then a 2-word short block.
        load_block(130, 129);
        run_stream(4'b1111, 1200);
        exp_cnt = exp_cnt + 16'd2;
        chk("long_nbytes", 64'(got_be.size()), 64'd520);
        pattern_check("long");
        chk("long_nlast", 64'(last_idx.size()), 64'd2);
        if (last_idx.size() > 1) begin
            chk("long_last_pos0", 64'(last_idx[0]), 64'd511);
            chk("long_last_pos1", 64'(last_idx[1]), 64'd519);
        end
        chk("long_long", 64'(n_long), 64'd1);
        chk("long_short", 64'(n_short), 64'd1);
        common_checks("long");

        // Reset after byte 1 of a word.
        @(negedge i_clk);
        s_valid = 1'b1; s_data = 32'hCAFEF00D; s_last = 1'b0; m_ready = 1'b1;
        #1 chk("rmw_accept", 64'(s_ready), 64'd1);
        @(negedge i_clk);
        s_valid = 1'b0;
        #1 chk("rmw_byte0", 64'(m_data), 64'hCA);
        @(negedge i_clk);
        #1 chk("rmw_byte1", 64'(m_data), 64'hFE);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        #1;
        chk("rmw_m_valid", 64'(m_valid), 64'd0);
        chk("rmw_m_last", 64'(m_last), 64'd0);
        chk("rmw_blk_count", 64'(o_blk_count), 64'd0);
        i_reset_n = 1'b1;
        exp_cnt = '0;
        stim_w.delete(); stim_l.delete();
        stim_w.push_back(32'h01020304);
        stim_l.push_back(1'b1);
        run_stream(4'b1111, 100);
        exp_cnt++;
        chk("rmw_nbytes", 64'(got_be.size()), 64'd4);
        if (got_be.size() == 4)
            chk("rmw_next_word", 64'({got_be[0], got_be[1], got_be[2], got_be[3]}), 64'h01020304);
        chk("rmw_short", 64'(n_short), 64'd1);
        common_checks("rmw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
